// File: rtl/radix4_pkg.sv
// Shared definitions for the radix-4 restoring divider: FSM state
// encoding and the default divisor width.
package radix4_pkg;

    // Default divisor width; dividend and quotient are twice this wide.
    localparam int DIV_N = 16;

    // Controller states. IDLE accepts operands, BUSY retires one
    // radix-4 digit per cycle, DONE presents the result until taken.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/radix4_divider_if.sv
// Operand/result bundle of the radix-4 divider.
//
// Handshake rules (both channels): a transfer happens on a rising clk
// edge where valid && ready are both high. The producer keeps valid and
// its data stable until that edge; ready never depends combinationally
// on valid. The input channel is in_valid/in_ready with dividend and
// divisor; the output channel is out_valid/out_ready with quotient,
// remainder and div_by_zero.
interface radix4_divider_if import radix4_pkg::*; #(
    parameter int N = DIV_N
) ();

    logic             in_valid;
    logic             in_ready;
    logic [2*N-1:0]   dividend;
    logic [N-1:0]     divisor;
    logic             out_valid;
    logic             out_ready;
    logic [2*N-1:0]   quotient;
    logic [N-1:0]     remainder;
    logic             div_by_zero;

    // Requester side: supplies operands and consumes results.
    modport master (
        output in_valid, dividend, divisor, out_ready,
        input  in_ready, out_valid, quotient, remainder, div_by_zero
    );

    // Divider side.
    modport slave (
        input  in_valid, dividend, divisor, out_ready,
        output in_ready, out_valid, quotient, remainder, div_by_zero
    );

endinterface

// File: rtl/radix4_qsel.sv
// Radix-4 quotient digit selection: given the shifted partial remainder
// and the multiples d, 2d, 3d, pick the largest digit whose multiple
// fits and return the difference. Purely combinational.
module radix4_qsel import radix4_pkg::*; #(
    parameter int N = DIV_N
) (
    input  logic [N+1:0] rem_shift,   // partial remainder << 2 | next two dividend bits
    input  logic [N-1:0] d,           // divisor
    input  logic [N+1:0] d3,          // precomputed 3*divisor
    output logic [1:0]   q,           // selected quotient digit
    output logic [N+1:0] diff         // rem_shift - q*d
);

    logic [N+1:0] d1;
    logic [N+1:0] d2;

    assign d1 = {2'b00, d};
    assign d2 = {1'b0, d, 1'b0};

    // Compare against the three multiples, largest first.
    always_comb begin
        q    = 2'd0;
        diff = rem_shift;
        if (rem_shift >= d3) begin
            q    = 2'd3;
            diff = rem_shift - d3;
        end else if (rem_shift >= d2) begin
            q    = 2'd2;
            diff = rem_shift - d2;
        end else if (rem_shift >= d1) begin
            q    = 2'd1;
            diff = rem_shift - d1;
        end
    end

endmodule

// File: rtl/radix4_divider.sv
// Sequential radix-4 unsigned divider: 2N-bit dividend by N-bit divisor,
// one quotient digit (two bits) per cycle, N cycles per division.
// A zero divisor short-circuits to an all-ones quotient with the low
// dividend half as remainder and div_by_zero set.
module radix4_divider import radix4_pkg::*; #(
    parameter int N = DIV_N   // must be even
) (
    input  logic            clk,
    input  logic            rst,
    radix4_divider_if.slave bus,
    output state_t          dbg_state
);

    localparam int CW = $clog2(N + 1);

    state_t         state_q;
    state_t         state_d;

    logic [N+1:0]   rem_q;    // partial remainder, always < divisor after a step
    logic [N+1:0]   d3_q;     // 3*divisor, held for the whole division
    logic [N-1:0]   div_q;    // registered divisor
    logic [2*N-1:0] dvd_q;    // dividend, consumed two bits per step from the top
    logic [2*N-1:0] quo_q;    // quotient, digits shifted in at the bottom
    logic           dbz_q;
    logic [CW-1:0]  cnt_q;    // remaining digit steps

    logic           accept;
    logic           divisor_zero;
    logic [N+1:0]   rem_shift;
    logic [N+1:0]   triple;
    logic [1:0]     qsel_q;
    logic [N+1:0]   qsel_diff;
    logic           rem_unused;

    assign accept       = (state_q == IDLE) && bus.in_valid;
    assign divisor_zero = (bus.divisor == '0);
    assign triple       = {2'b00, bus.divisor} + {1'b0, bus.divisor, 1'b0};

    // The remainder is below the divisor, so its low N bits carry all
    // information; the next two dividend bits enter at the bottom.
    assign rem_shift  = {rem_q[N-1:0], dvd_q[2*N-1:2*N-2]};
    assign rem_unused = ^rem_q[N+1:N];

    radix4_qsel #(.N(N)) u_qsel (
        .rem_shift (rem_shift),
        .d         (div_q),
        .d3        (d3_q),
        .q         (qsel_q),
        .diff      (qsel_diff)
    );

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic: zero divisor skips BUSY; DONE waits for out_ready.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    state_d = divisor_zero ? DONE : BUSY;
                end
            end
            BUSY: begin
                if (cnt_q == CW'(1)) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                if (bus.out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Datapath: load on accept, one digit step per BUSY cycle, hold otherwise.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rem_q <= '0;
            d3_q  <= '0;
            div_q <= '0;
            dvd_q <= '0;
            quo_q <= '0;
            dbz_q <= 1'b0;
            cnt_q <= '0;
        end else if (accept) begin
            div_q <= bus.divisor;
            if (divisor_zero) begin
                rem_q <= {2'b00, bus.dividend[N-1:0]};
                d3_q  <= '0;
                dvd_q <= '0;
                quo_q <= '1;
                dbz_q <= 1'b1;
                cnt_q <= '0;
            end else begin
                rem_q <= '0;
                d3_q  <= triple;
                dvd_q <= bus.dividend;
                quo_q <= '0;
                dbz_q <= 1'b0;
                cnt_q <= CW'(N);
            end
        end else if (state_q == BUSY) begin
            rem_q <= qsel_diff;
            dvd_q <= {dvd_q[2*N-3:0], 2'b00};
            quo_q <= {quo_q[2*N-3:0], qsel_q};
            cnt_q <= cnt_q - CW'(1);
        end
    end

    assign bus.in_ready    = (state_q == IDLE);
    assign bus.out_valid   = (state_q == DONE);
    assign bus.quotient    = quo_q;
    assign bus.remainder   = rem_q[N-1:0];
    assign bus.div_by_zero = dbz_q;
    assign dbg_state       = state_q;

endmodule

// File: tb/tb_radix4_divider.sv
// Bench for radix4_divider: table of directed vectors, hand-written
// hold/reset sequences, and random operands scored against an
// arithmetic reference model.
module tb_radix4_divider;
    import radix4_pkg::*;

    localparam int N = 16;
    localparam int W = 2 * N + N + 1;   // {quotient, remainder, div_by_zero}

    typedef logic [2*N-1:0] dvd_t;
    typedef logic [N-1:0]   dvs_t;

    typedef struct {
        string name;
        dvd_t  a;
        dvs_t  b;
        dvd_t  q;
        dvs_t  r;
        logic  dbz;
        int    lat;
    } vec_t;

    logic   clk;
    logic   rst;
    state_t dbg_state;

    int checks   = 0;
    int failures = 0;
    logic [W-1:0] exp_q[$];

    radix4_divider_if #(.N(N)) bus ();

    radix4_divider #(.N(N)) dut (
        .clk       (clk),
        .rst       (rst),
        .bus       (bus),
        .dbg_state (dbg_state)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation time limit reached, checks=%0d", checks);
        $fatal(1, "watchdog");
    end

    // ---------------- checking helpers ----------------
    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
        end
    endtask

    // Reference: plain arithmetic division; zero divisor gives the
    // saturated quotient and the low dividend half as remainder.
    function automatic logic [W-1:0] model(input dvd_t a, input dvs_t b);
        dvd_t bw;
        dvd_t q;
        dvd_t r;
        if (b == '0) begin
            return {{(2*N){1'b1}}, a[N-1:0], 1'b1};
        end
        bw = {{N{1'b0}}, b};
        q  = a / bw;
        r  = a % bw;
        return {q, r[N-1:0], 1'b0};
    endfunction

    task automatic check_res(input string tag, input logic [W-1:0] res, input logic [W-1:0] exp_v,
                             input int lat, input int exp_lat);
        check({tag, ".quotient"},  64'(res[W-1:N+1]), 64'(exp_v[W-1:N+1]));
        check({tag, ".remainder"}, 64'(res[N:1]),     64'(exp_v[N:1]));
        check({tag, ".dbz"},       64'(res[0]),       64'(exp_v[0]));
        check({tag, ".latency"},   64'(lat),          64'(exp_lat));
    endtask

    // ---------------- driver ----------------
    // Issues one operation with out_ready assumed high. lat counts rising
    // edges from the accept edge (=1) until out_valid is seen.
    task automatic run_op(input dvd_t a, input dvs_t b, output logic [W-1:0] res, output int lat);
        int guard;
        @(negedge clk);
        guard = 0;
        while (!bus.in_ready && guard < 200) begin
            @(negedge clk);
            guard++;
        end
        bus.dividend = a;
        bus.divisor  = b;
        bus.in_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        lat = 1;
        bus.in_valid = 1'($urandom_range(0, 1));
        bus.dividend = dvd_t'($urandom);
        bus.divisor  = dvs_t'($urandom);
        while (!bus.out_valid && lat < 100) begin
            @(negedge clk);
            lat++;
            bus.in_valid = 1'($urandom_range(0, 1));
            bus.dividend = dvd_t'($urandom);
            bus.divisor  = dvs_t'($urandom);
        end
        res = {bus.quotient, bus.remainder, bus.div_by_zero};
        @(posedge clk);
        @(negedge clk);
        check("handoff.in_ready", 64'(bus.in_ready), 64'(1));
        check("handoff.state",    64'(dbg_state),    64'(IDLE));
        bus.in_valid = 1'b0;
    endtask

    // ---------------- test ----------------
    vec_t vecs[12];

    initial begin
        logic [W-1:0] res;
        logic [W-1:0] expv;
        int           lat;
        int           seen;
        int           guard;

        vecs[0]  = '{"v7_3",       32'd7,          16'd3,      32'd2,          16'd1,      1'b0, 17};
        vecs[1]  = '{"vmax_ffff",  32'hFFFF_FFFF,  16'hFFFF,   32'h0001_0001,  16'h0,      1'b0, 17};
        vecs[2]  = '{"v1e6_1000",  32'd1000000,    16'd1000,   32'd1000,       16'd0,      1'b0, 17};
        vecs[3]  = '{"vdbz",       32'h1234_5678,  16'd0,      32'hFFFF_FFFF,  16'h5678,   1'b1, 1};
        vecs[4]  = '{"v100_7",     32'd100,        16'd7,      32'd14,         16'd2,      1'b0, 17};
        vecs[5]  = '{"vzero_num",  32'd0,          16'd5,      32'd0,          16'd0,      1'b0, 17};
        vecs[6]  = '{"vsmall",     32'd5,          16'd7,      32'd0,          16'd5,      1'b0, 17};
        vecs[7]  = '{"vdiv1",      32'hFFFF_FFFF,  16'd1,      32'hFFFF_FFFF,  16'd0,      1'b0, 17};
        vecs[8]  = '{"vdiv2",      32'hFFFF_FFFF,  16'd2,      32'h7FFF_FFFF,  16'd1,      1'b0, 17};
        vecs[9]  = '{"vsquare",    32'hFFFE_0001,  16'hFFFF,   32'h0000_FFFF,  16'd0,      1'b0, 17};
        vecs[10] = '{"vdbz_low",   32'h0000_FFFF,  16'd0,      32'hFFFF_FFFF,  16'hFFFF,   1'b1, 1};
        vecs[11] = '{"v3",         32'd8,          16'd3,      32'd2,          16'd2,      1'b0, 17};

        bus.in_valid  = 1'b0;
        bus.dividend  = '0;
        bus.divisor   = '0;
        bus.out_ready = 1'b1;
        rst           = 1'b1;

        // Reset state
        #1;
        check("rst.out_valid", 64'(bus.out_valid),   64'(0));
        check("rst.quotient",  64'(bus.quotient),    64'(0));
        check("rst.remainder", 64'(bus.remainder),   64'(0));
        check("rst.dbz",       64'(bus.div_by_zero), 64'(0));
        check("rst.state",     64'(dbg_state),       64'(IDLE));
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("rst.in_ready",  64'(bus.in_ready),    64'(1));

        // Directed vectors
        for (int i = 0; i < 12; i++) begin
            run_op(vecs[i].a, vecs[i].b, res, lat);
            check_res(vecs[i].name, res, {vecs[i].q, vecs[i].r, vecs[i].dbz}, lat, vecs[i].lat);
        end

        // Hold in DONE with out_ready low for 10 cycles
        bus.out_ready = 1'b0;
        expv = model(32'h1234_5678, 16'h1234);
        @(negedge clk);
        bus.dividend = 32'h1234_5678;
        bus.divisor  = 16'h1234;
        bus.in_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus.in_valid = 1'b0;
        guard = 0;
        while (!bus.out_valid && guard < 100) begin
            @(negedge clk);
            guard++;
        end
        check("hold.reached", 64'(bus.out_valid), 64'(1));
        for (int k = 0; k < 10; k++) begin
            check("hold.result",    {15'd0, bus.quotient, bus.remainder, bus.div_by_zero}, 64'(expv));
            check("hold.in_ready",  64'(bus.in_ready),  64'(0));
            check("hold.out_valid", 64'(bus.out_valid), 64'(1));
            bus.in_valid = 1'($urandom_range(0, 1));
            bus.dividend = dvd_t'($urandom);
            bus.divisor  = dvs_t'($urandom);
            @(negedge clk);
        end
        bus.in_valid  = 1'b1;
        bus.out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check("release.out_valid", 64'(bus.out_valid), 64'(0));
        check("release.in_ready",  64'(bus.in_ready),  64'(1));
        check("release.state",     64'(dbg_state),     64'(IDLE));
        bus.in_valid = 1'b0;

        // Reset in the middle of BUSY aborts the operation
        @(negedge clk);
        bus.dividend = 32'h0000_FFFF;
        bus.divisor  = 16'd3;
        bus.in_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus.in_valid = 1'b0;
        repeat (7) @(posedge clk);
        #1;
        check("midbusy.state_before", 64'(dbg_state), 64'(BUSY));
        rst = 1'b1;
        #1;
        check("midbusy.out_valid", 64'(bus.out_valid), 64'(0));
        check("midbusy.quotient",  64'(bus.quotient),  64'(0));
        check("midbusy.remainder", 64'(bus.remainder), 64'(0));
        check("midbusy.state",     64'(dbg_state),     64'(IDLE));
        @(negedge clk);
        rst = 1'b0;
        seen = 0;
        for (int k = 0; k < 30; k++) begin
            @(negedge clk);
            if (bus.out_valid) seen++;
        end
        check("midbusy.no_result", 64'(seen), 64'(0));
        run_op(32'd100, 16'd7, res, lat);
        check_res("after_rst", res, {32'd14, 16'd2, 1'b0}, lat, 17);

        // Reset while a result waits in DONE discards it
        bus.out_ready = 1'b0;
        @(negedge clk);
        bus.dividend = 32'd999;
        bus.divisor  = 16'd10;
        bus.in_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus.in_valid = 1'b0;
        guard = 0;
        while (!bus.out_valid && guard < 100) begin
            @(negedge clk);
            guard++;
        end
        check("done_rst.reached", 64'(bus.out_valid), 64'(1));
        rst = 1'b1;
        #1;
        check("done_rst.out_valid", 64'(bus.out_valid), 64'(0));
        check("done_rst.dbz",       64'(bus.div_by_zero), 64'(0));
        @(negedge clk);
        rst = 1'b0;
        bus.out_ready = 1'b1;
        seen = 0;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (bus.out_valid) seen++;
        end
        check("done_rst.no_result", 64'(seen), 64'(0));

        // Products x*y divided by y must recover x with zero remainder
        for (int i = 0; i < 50; i++) begin
            dvs_t x;
            dvs_t y;
            dvd_t p;
            x = dvs_t'($urandom_range(0, 65535));
            y = dvs_t'($urandom_range(1, 65535));
            p = dvd_t'(x) * dvd_t'(y);
            exp_q.push_back({dvd_t'(x), dvs_t'(0), 1'b0});
            run_op(p, y, res, lat);
            expv = exp_q.pop_front();
            $display("csv,%0d,%0d,%0d,%0d,%0d", p, y, res[W-1:N+1], res[N:1], res[0]);
            check_res("prod", res, expv, lat, 17);
        end

        // Arbitrary operands, including zero and tiny divisors
        for (int i = 0; i < 30; i++) begin
            dvd_t a;
            dvs_t b;
            a = dvd_t'($urandom);
            if (i % 10 == 0)      b = '0;
            else if (i % 3 == 0)  b = dvs_t'($urandom_range(1, 4));
            else                  b = dvs_t'($urandom_range(1, 65535));
            exp_q.push_back(model(a, b));
            run_op(a, b, res, lat);
            expv = exp_q.pop_front();
            check_res("rand", res, expv, lat, (b == '0) ? 1 : 17);
        end

        check("scoreboard.empty", 64'(exp_q.size()), 64'(0));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
